// File: rtl/wb_cpu_arbiter.sv
// Two-master Wishbone arbiter (icache CMU = master 0, dcache CMU = master 1); grant 1 cycle after cyc, bus mux combinational from state.
// Loser holds cyc/stb until granted; hung slaves answered with ack+err after TIMEOUT strobe cycles. ARB_ROUND_ROBIN_EN selects round-robin.
module wb_cpu_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        wbs0_cyc_i,
  input  logic        wbs0_stb_i,
  input  logic [31:2] wbs0_addr_i,
  input  logic [2:0]  wbs0_cti_i,
  input  logic [1:0]  wbs0_bte_i,
  input  logic [3:0]  wbs0_sel_i,
  input  logic        wbs0_we_i,
  input  logic [31:0] wbs0_data_i,
  output logic [31:0] wbs0_data_o,
  output logic        wbs0_ack_o,
  output logic        wbs0_err_o,

  input  logic        wbs1_cyc_i,
  input  logic        wbs1_stb_i,
  input  logic [31:2] wbs1_addr_i,
  input  logic [2:0]  wbs1_cti_i,
  input  logic [1:0]  wbs1_bte_i,
  input  logic [3:0]  wbs1_sel_i,
  input  logic        wbs1_we_i,
  input  logic [31:0] wbs1_data_i,
  output logic [31:0] wbs1_data_o,
  output logic        wbs1_ack_o,
  output logic        wbs1_err_o,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:2] wbm_addr_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i,

  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OWN0 = 2'b01,
    S_OWN1 = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t      state_q;
  logic [1:0]  grant_q;
  logic [7:0]  wait_q;

  logic own0, own1;
  logic own_cyc, own_stb;
  logic timeout, ack_fwd;
  logic pick0, pick1;

  assign own0    = (state_q == S_OWN0);
  assign own1    = (state_q == S_OWN1);
  assign own_cyc = (own0 & wbs0_cyc_i) | (own1 & wbs1_cyc_i);
  assign own_stb = (own0 & wbs0_stb_i) | (own1 & wbs1_stb_i);
  assign timeout = own_stb && (wait_q == TIMEOUT_CNT);
  assign ack_fwd = own_stb & wbm_ack_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;
  // On a tie, favour whichever master did not hold the bus last.
  assign pick1 = wbs1_cyc_i & (~wbs0_cyc_i | ~last_owner_q);
`else
  assign pick1 = wbs1_cyc_i;
`endif
  assign pick0 = wbs0_cyc_i & ~pick1;

  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_addr_o = '0;
    wbm_cti_o  = '0;
    wbm_bte_o  = '0;
    wbm_sel_o  = '0;
    wbm_we_o   = 1'b0;
    wbm_data_o = '0;
    if (own0) begin
      wbm_addr_o = wbs0_addr_i;
      wbm_cti_o  = wbs0_cti_i;
      wbm_bte_o  = wbs0_bte_i;
      wbm_sel_o  = wbs0_sel_i;
      wbm_we_o   = wbs0_we_i;
      wbm_data_o = wbs0_data_i;
    end else if (own1) begin
      wbm_addr_o = wbs1_addr_i;
      wbm_cti_o  = wbs1_cti_i;
      wbm_bte_o  = wbs1_bte_i;
      wbm_sel_o  = wbs1_sel_i;
      wbm_we_o   = wbs1_we_i;
      wbm_data_o = wbs1_data_i;
    end
    // A timed-out beat is withdrawn from the bus while the owner gets its synthesized ack.
    wbm_cyc_o = own_cyc & ~timeout;
    wbm_stb_o = own_stb & ~timeout;
  end

  assign wbs0_ack_o  = own0 & (timeout | ack_fwd);
  assign wbs0_err_o  = own0 & timeout;
  assign wbs0_data_o = (own0 & ~timeout) ? wbm_data_i : 32'h0;
  assign wbs1_ack_o  = own1 & (timeout | ack_fwd);
  assign wbs1_err_o  = own1 & timeout;
  assign wbs1_data_o = (own1 & ~timeout) ? wbm_data_i : 32'h0;

  assign grant = grant_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      wait_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_q <= '0;
          if (pick1) begin
            state_q <= S_OWN1;
            grant_q <= 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
          end else if (pick0) begin
            state_q <= S_OWN0;
            grant_q <= 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b0;
`endif
          end
        end
        S_OWN0, S_OWN1: begin
          // Release always passes through idle, giving the bus a turnaround cycle.
          if (!own_cyc) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            wait_q  <= '0;
          end else if (timeout || ack_fwd) begin
            wait_q <= '0;
          end else if (own_stb) begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 2'b00;
          wait_q  <= '0;
        end
      endcase
    end
  end

endmodule
